// File: rtl/mac_pkg.sv
// Shared defaults and the saturating accumulator add for mac_dot_accum.
// sat_add is only referenced when MAC_SAT_EN is defined.
package mac_pkg;
   localparam int unsigned MAC_DATA_W = 22;
   localparam int unsigned MAC_LANES  = 4;
   localparam int unsigned MAC_ACC_W  = 48;
   localparam int unsigned MAC_BEAT_W = 16;

   typedef logic signed [MAC_ACC_W-1:0] acc_t;

   typedef struct packed {
      logic ovf;
      acc_t sum;
   } sat_sum_t;

   // Two's-complement add clamped to the signed range; ovf flags a clamp.
   function automatic sat_sum_t sat_add(input acc_t a, input acc_t b);
      sat_sum_t r;
      acc_t     s;
      s     = a + b;
      r.ovf = (a[MAC_ACC_W-1] == b[MAC_ACC_W-1]) && (s[MAC_ACC_W-1] != a[MAC_ACC_W-1]);
      if (r.ovf) begin
         r.sum = a[MAC_ACC_W-1] ? {1'b1, {(MAC_ACC_W-1){1'b0}}}
                                : {1'b0, {(MAC_ACC_W-1){1'b1}}};
      end else begin
         r.sum = s;
      end
      return r;
   endfunction
endpackage

// File: rtl/mac_dot_accum_if.sv
// Beat input stream and result output stream of mac_dot_accum.
// master drives beats and o_ready; slave is the MAC itself.
interface mac_dot_accum_if
   import mac_pkg::*;
#(
   parameter int unsigned DATA_W = MAC_DATA_W,
   parameter int unsigned LANES  = MAC_LANES,
   parameter int unsigned ACC_W  = MAC_ACC_W,
   parameter int unsigned BEAT_W = MAC_BEAT_W
);
   logic                    i_valid;
   logic                    i_ready;
   logic                    i_first;
   logic                    i_last;
   logic [LANES*DATA_W-1:0] data_a;
   logic [LANES*DATA_W-1:0] data_b;
   logic                    o_valid;
   logic                    o_ready;
   logic [ACC_W-1:0]        o_sum;
   logic [BEAT_W-1:0]       o_beats;
   logic                    o_ovf;

   modport master (
      output i_valid, i_first, i_last, data_a, data_b, o_ready,
      input  i_ready, o_valid, o_sum, o_beats, o_ovf
   );

   modport slave (
      input  i_valid, i_first, i_last, data_a, data_b, o_ready,
      output i_ready, o_valid, o_sum, o_beats, o_ovf
   );
endinterface

// File: rtl/mac_adder_tree.sv
// Signed reduction of LANES products to one sum, registered under adv.
// Forms pipeline stage S3 of mac_dot_accum.
module mac_adder_tree #(
   parameter int unsigned LANES = 4,
   parameter int unsigned IN_W  = 44,
   parameter int unsigned OUT_W = IN_W + $clog2(LANES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    adv,
   input  logic [LANES*IN_W-1:0]   prods,
   output logic signed [OUT_W-1:0] sum_q
);
   logic signed [OUT_W-1:0] node [2*LANES-1];
   logic signed [OUT_W-1:0] sum_d;

   // Heap layout: leaves at LANES-1.., node k-1 sums children 2k-1 and 2k.
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         node[LANES-1+i] = OUT_W'($signed(prods[i*IN_W +: IN_W]));
      end
      for (int unsigned k = LANES - 1; k > 0; k--) begin
         node[k-1] = node[2*k-1] + node[2*k];
      end
      sum_d = adv ? node[0] : sum_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_q <= '0;
      else      sum_q <= sum_d;
   end
endmodule

// File: rtl/mac_dot_accum.sv
// Four-stage multi-lane MAC accumulating dot products over i_first/i_last frames.
// Define MAC_SAT_EN for a saturating accumulator and the o_ovf flag.
module mac_dot_accum
   import mac_pkg::*;
#(
   parameter int unsigned DATA_W = MAC_DATA_W,
   parameter int unsigned LANES  = MAC_LANES,
   parameter int unsigned ACC_W  = MAC_ACC_W,
   parameter int unsigned BEAT_W = MAC_BEAT_W
) (
   input logic            clk,
   input logic            rst,
   mac_dot_accum_if.slave bus
);
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned TREE_W = PROD_W + $clog2(LANES);

   logic                    adv;
   logic [LANES*DATA_W-1:0] a1_d, a1_q, b1_d, b1_q;
   logic                    v1_d, v1_q, f1_d, f1_q, l1_d, l1_q;
   logic signed [PROD_W-1:0] ext_a, ext_b;
   logic [LANES*PROD_W-1:0] p2_d, p2_q;
   logic                    v2_d, v2_q, f2_d, f2_q, l2_d, l2_q;
   logic signed [TREE_W-1:0] tree_q;
   logic                    v3_d, v3_q, f3_d, f3_q, l3_d, l3_q;
   logic signed [ACC_W-1:0] tree_ext, acc_base, acc_next, acc_d, acc_q;
   logic [BEAT_W-1:0]       cnt_next, cnt_d, cnt_q;
   logic [ACC_W-1:0]        o_sum_d, o_sum_q;
   logic [BEAT_W-1:0]       o_beats_d, o_beats_q;
   logic                    o_valid_d, o_valid_q;
`ifdef MAC_SAT_EN
   sat_sum_t                sat_res;
   logic                    ovf_next, ovf_d, ovf_q, o_ovf_d, o_ovf_q;
`endif

   assign adv         = !(o_valid_q && !bus.o_ready);
   assign bus.i_ready = adv;

   always_comb begin
      a1_d  = adv ? bus.data_a  : a1_q;
      b1_d  = adv ? bus.data_b  : b1_q;
      v1_d  = adv ? bus.i_valid : v1_q;
      f1_d  = adv ? bus.i_first : f1_q;
      l1_d  = adv ? bus.i_last  : l1_q;
      v2_d  = adv ? v1_q : v2_q;
      f2_d  = adv ? f1_q : f2_q;
      l2_d  = adv ? l1_q : l2_q;
      v3_d  = adv ? v2_q : v3_q;
      f3_d  = adv ? f2_q : f3_q;
      l3_d  = adv ? l2_q : l3_q;
      p2_d  = p2_q;
      ext_a = '0;
      ext_b = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         ext_a = {{DATA_W{a1_q[i*DATA_W+DATA_W-1]}}, a1_q[i*DATA_W +: DATA_W]};
         ext_b = {{DATA_W{b1_q[i*DATA_W+DATA_W-1]}}, b1_q[i*DATA_W +: DATA_W]};
         if (adv) p2_d[i*PROD_W +: PROD_W] = ext_a * ext_b;
      end
   end

   mac_adder_tree #(
      .LANES (LANES),
      .IN_W  (PROD_W),
      .OUT_W (TREE_W)
   ) u_tree (
      .clk   (clk),
      .rst   (rst),
      .adv   (adv),
      .prods (p2_q),
      .sum_q (tree_q)
   );

   always_comb begin
      tree_ext = ACC_W'(tree_q);
      acc_base = f3_q ? '0 : acc_q;
`ifdef MAC_SAT_EN
      sat_res  = sat_add(acc_base, tree_ext);
      acc_next = sat_res.sum;
      ovf_next = (f3_q ? 1'b0 : ovf_q) | sat_res.ovf;
      ovf_d    = ovf_q;
      o_ovf_d  = o_ovf_q;
`else
      acc_next = acc_base + tree_ext;
`endif
      cnt_next  = f3_q ? BEAT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      o_sum_d   = o_sum_q;
      o_beats_d = o_beats_q;
      o_valid_d = o_valid_q;
      if (o_valid_q && bus.o_ready) o_valid_d = 1'b0;
      // A last beat retires the frame into the output register and clears the running state.
      if (adv && v3_q) begin
         if (l3_q) begin
            o_sum_d   = acc_next;
            o_beats_d = cnt_next;
            o_valid_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
`ifdef MAC_SAT_EN
            o_ovf_d   = ovf_next;
            ovf_d     = 1'b0;
`endif
         end else begin
            acc_d     = acc_next;
            cnt_d     = cnt_next;
`ifdef MAC_SAT_EN
            ovf_d     = ovf_next;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a1_q      <= '0;
         b1_q      <= '0;
         v1_q      <= 1'b0;
         f1_q      <= 1'b0;
         l1_q      <= 1'b0;
         p2_q      <= '0;
         v2_q      <= 1'b0;
         f2_q      <= 1'b0;
         l2_q      <= 1'b0;
         v3_q      <= 1'b0;
         f3_q      <= 1'b0;
         l3_q      <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         o_sum_q   <= '0;
         o_beats_q <= '0;
         o_valid_q <= 1'b0;
`ifdef MAC_SAT_EN
         ovf_q     <= 1'b0;
         o_ovf_q   <= 1'b0;
`endif
      end else begin
         a1_q      <= a1_d;
         b1_q      <= b1_d;
         v1_q      <= v1_d;
         f1_q      <= f1_d;
         l1_q      <= l1_d;
         p2_q      <= p2_d;
         v2_q      <= v2_d;
         f2_q      <= f2_d;
         l2_q      <= l2_d;
         v3_q      <= v3_d;
         f3_q      <= f3_d;
         l3_q      <= l3_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         o_sum_q   <= o_sum_d;
         o_beats_q <= o_beats_d;
         o_valid_q <= o_valid_d;
`ifdef MAC_SAT_EN
         ovf_q     <= ovf_d;
         o_ovf_q   <= o_ovf_d;
`endif
      end
   end

   assign bus.o_valid = o_valid_q;
   assign bus.o_sum   = o_sum_q;
   assign bus.o_beats = o_beats_q;
`ifdef MAC_SAT_EN
   assign bus.o_ovf   = o_ovf_q;
`else
   assign bus.o_ovf   = 1'b0;
`endif
endmodule
